// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/mode-change controller.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } trap_state_e;

  localparam logic [1:0] VEC_DIRECT   = 2'd0;
  localparam logic [1:0] VEC_VECTORED = 2'd1;
  localparam int         CAUSE_MSB    = 31;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: index, one-hot and valid of the winning request.
module prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx    = '0;
    onehot = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap and mode-change controller: captures the pipeline tail, prioritises exceptions
// over pending interrupts and holds a trap until the front end acknowledges it.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int STAGES  = 6,
  parameter int NUM_INT = 8,
  parameter int CODE_W  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                FLUSH,
  input  logic                MMU_WAIT,
  input  logic [STAGES*32-1:0] STAGE_PC,
  input  logic                EXC_EN,
  input  logic [CODE_W-1:0]   EXC_CODE,
  input  logic                CHMODE_DO_IN,
  input  logic [1:0]          CHMODE_TRANS_TO_IN,
  input  logic                INT_ALLOW,
  input  logic [NUM_INT-1:0]  INT_REQ,
  input  logic [NUM_INT-1:0]  INT_MASK,
  input  logic [NUM_INT-1:0]  INT_CLR,
  input  logic [1:0]          TRAP_VEC_MODE,
  input  logic [31:0]         TRAP_VEC_BASE,
  input  logic                TRAP_ACK,
  output logic                TRAP_EN,
  output logic [31:0]         TRAP_PC,
  output logic [31:0]         TRAP_CODE,
  output logic [31:0]         TRAP_JMP_TO,
  output logic                CHMODE_DO,
  output logic [1:0]          CHMODE_TRANS_TO,
  output logic [31:0]         CHMODE_JMP_TO,
  output logic [NUM_INT-1:0]  INT_PENDING
);

  logic [STAGES*32-1:0] pc_q;
  logic                 exc_en_q;
  logic [CODE_W-1:0]    exc_code_q;
  logic                 chm_do_q;
  logic [1:0]           chm_to_q;
  logic [1:0]           vec_mode_q;
  logic [31:0]          vec_base_q;
  logic                 allow_q;
  logic [NUM_INT-1:0]   pend_q;
  trap_state_e          state_q;
  logic                 is_int_q;
  logic [NUM_INT-1:0]   taken_oh_q;

  logic [NUM_INT-1:0]   eligible;
  logic [CODE_W-1:0]    int_idx;
  logic [NUM_INT-1:0]   int_oh;
  logic                 int_valid;
  logic                 trap_req;
  logic                 ack_ok;
  logic                 chm_gate;
  logic [NUM_INT-1:0]   taken;
  logic [31:0]          sel_pc;
  logic [31:0]          next_code;
  logic [31:0]          next_jmp;

  assign eligible = allow_q ? (pend_q & INT_MASK) : '0;

  prio_enc #(.N(NUM_INT), .IDX_W(CODE_W)) u_prio (
    .req   (eligible),
    .idx   (int_idx),
    .onehot(int_oh),
    .valid (int_valid)
  );

  assign trap_req    = exc_en_q | int_valid;
  assign ack_ok      = (state_q == ISSUE) && TRAP_ACK && !MMU_WAIT;
  assign taken       = (ack_ok && is_int_q) ? taken_oh_q : '0;
  assign chm_gate    = (state_q == IDLE) && !trap_req;
  assign INT_PENDING = pend_q;

  always_comb begin
    sel_pc = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (pc_q[32*i +: 32] != 32'd0) sel_pc = pc_q[32*i +: 32];
    end
    next_code = exc_en_q ? 32'(exc_code_q) : 32'(int_idx);
    next_code[CAUSE_MSB] = !exc_en_q;
    next_jmp = vec_base_q;
    if (vec_mode_q == VEC_VECTORED && !exc_en_q)
      next_jmp = vec_base_q + (32'(int_idx) << 2);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q       <= '0;
      exc_en_q   <= 1'b0;
      exc_code_q <= '0;
      chm_do_q   <= 1'b0;
      chm_to_q   <= '0;
      vec_mode_q <= '0;
      vec_base_q <= '0;
      allow_q    <= 1'b0;
    end else if (!MMU_WAIT) begin
      if (FLUSH) begin
        pc_q       <= '0;
        exc_en_q   <= 1'b0;
        exc_code_q <= '0;
        chm_do_q   <= 1'b0;
        chm_to_q   <= '0;
        vec_mode_q <= '0;
        vec_base_q <= '0;
        allow_q    <= 1'b0;
      end else begin
        pc_q       <= STAGE_PC;
        exc_en_q   <= EXC_EN;
        exc_code_q <= EXC_CODE;
        chm_do_q   <= CHMODE_DO_IN;
        chm_to_q   <= CHMODE_TRANS_TO_IN;
        vec_mode_q <= TRAP_VEC_MODE;
        vec_base_q <= TRAP_VEC_BASE;
        allow_q    <= INT_ALLOW;
      end
    end
  end

  // Pending bits keep tracking requests through MMU stalls; a new request beats a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pend_q <= '0;
    else        pend_q <= (pend_q & ~INT_CLR & ~taken) | INT_REQ;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      TRAP_EN     <= 1'b0;
      TRAP_PC     <= '0;
      TRAP_CODE   <= '0;
      TRAP_JMP_TO <= '0;
      is_int_q    <= 1'b0;
      taken_oh_q  <= '0;
    end else if (!MMU_WAIT) begin
      case (state_q)
        IDLE: begin
          if (trap_req) begin
            state_q     <= ISSUE;
            TRAP_EN     <= 1'b1;
            TRAP_PC     <= sel_pc;
            TRAP_CODE   <= next_code;
            TRAP_JMP_TO <= next_jmp;
            is_int_q    <= !exc_en_q;
            taken_oh_q  <= exc_en_q ? '0 : int_oh;
          end
        end
        ISSUE: begin
          if (TRAP_ACK) begin
            state_q <= DRAIN;
            TRAP_EN <= 1'b0;
          end
        end
        DRAIN: begin
          if (FLUSH) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          TRAP_EN <= 1'b0;
        end
      endcase
    end
  end

  // A trap issued from IDLE suppresses any mode change captured alongside it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CHMODE_DO       <= 1'b0;
      CHMODE_TRANS_TO <= '0;
      CHMODE_JMP_TO   <= '0;
    end else begin
      CHMODE_DO       <= chm_gate & chm_do_q;
      CHMODE_TRANS_TO <= chm_gate ? chm_to_q : 2'd0;
      CHMODE_JMP_TO   <= chm_gate ? (pc_q[31:0] + 32'd4) : 32'd0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

  localparam int STAGES  = 6;
  localparam int NUM_INT = 8;
  localparam int CODE_W  = 4;

  logic                  CLK = 1'b0;
  logic                  RST_N;
  logic                  FLUSH;
  logic                  MMU_WAIT;
  logic [STAGES*32-1:0]  STAGE_PC;
  logic                  EXC_EN;
  logic [CODE_W-1:0]     EXC_CODE;
  logic                  CHMODE_DO_IN;
  logic [1:0]            CHMODE_TRANS_TO_IN;
  logic                  INT_ALLOW;
  logic [NUM_INT-1:0]    INT_REQ;
  logic [NUM_INT-1:0]    INT_MASK;
  logic [NUM_INT-1:0]    INT_CLR;
  logic [1:0]            TRAP_VEC_MODE;
  logic [31:0]           TRAP_VEC_BASE;
  logic                  TRAP_ACK;
  logic                  TRAP_EN;
  logic [31:0]           TRAP_PC;
  logic [31:0]           TRAP_CODE;
  logic [31:0]           TRAP_JMP_TO;
  logic                  CHMODE_DO;
  logic [1:0]            CHMODE_TRANS_TO;
  logic [31:0]           CHMODE_JMP_TO;
  logic [NUM_INT-1:0]    INT_PENDING;

  int checkCount = 0;
  int errorCount = 0;

  trap_ctrl #(.STAGES(STAGES), .NUM_INT(NUM_INT), .CODE_W(CODE_W)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .FLUSH             (FLUSH),
    .MMU_WAIT          (MMU_WAIT),
    .STAGE_PC          (STAGE_PC),
    .EXC_EN            (EXC_EN),
    .EXC_CODE          (EXC_CODE),
    .CHMODE_DO_IN      (CHMODE_DO_IN),
    .CHMODE_TRANS_TO_IN(CHMODE_TRANS_TO_IN),
    .INT_ALLOW         (INT_ALLOW),
    .INT_REQ           (INT_REQ),
    .INT_MASK          (INT_MASK),
    .INT_CLR           (INT_CLR),
    .TRAP_VEC_MODE     (TRAP_VEC_MODE),
    .TRAP_VEC_BASE     (TRAP_VEC_BASE),
    .TRAP_ACK          (TRAP_ACK),
    .TRAP_EN           (TRAP_EN),
    .TRAP_PC           (TRAP_PC),
    .TRAP_CODE         (TRAP_CODE),
    .TRAP_JMP_TO       (TRAP_JMP_TO),
    .CHMODE_DO         (CHMODE_DO),
    .CHMODE_TRANS_TO   (CHMODE_TRANS_TO),
    .CHMODE_JMP_TO     (CHMODE_JMP_TO),
    .INT_PENDING       (INT_PENDING)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clearInputs();
    FLUSH = 1'b0; MMU_WAIT = 1'b0; STAGE_PC = '0; EXC_EN = 1'b0; EXC_CODE = '0;
    CHMODE_DO_IN = 1'b0; CHMODE_TRANS_TO_IN = '0; INT_ALLOW = 1'b0; INT_REQ = '0;
    INT_MASK = '0; INT_CLR = '0; TRAP_VEC_MODE = '0; TRAP_VEC_BASE = '0; TRAP_ACK = 1'b0;
  endtask

  task automatic resetDut();
    RST_N = 1'b0;
    clearInputs();
    applyStimulus(2);
    RST_N = 1'b1;
    applyStimulus(1);
  endtask

  initial begin
    $display("[TB] trap_ctrl directed test start");
    resetDut();
    checkOutput("reset_trap_en", 32'(TRAP_EN), 32'd0);
    checkOutput("reset_trap_pc", TRAP_PC, 32'd0);
    checkOutput("reset_trap_code", TRAP_CODE, 32'd0);
    checkOutput("reset_chmode_do", 32'(CHMODE_DO), 32'd0);
    checkOutput("reset_pending", 32'(INT_PENDING), 32'd0);

    // Exception with oldest stage a bubble
    STAGE_PC[32*1 +: 32] = 32'h0000_0100;
    STAGE_PC[32*2 +: 32] = 32'h0000_0104;
    STAGE_PC[32*3 +: 32] = 32'h0000_0108;
    EXC_EN = 1'b1; EXC_CODE = 4'd2;
    TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h8000_0000;
    applyStimulus(1);
    checkOutput("exc_en_cycle1", 32'(TRAP_EN), 32'd0);
    EXC_EN = 1'b0;
    applyStimulus(1);
    checkOutput("exc_en_cycle2", 32'(TRAP_EN), 32'd1);
    checkOutput("exc_pc", TRAP_PC, 32'h0000_0100);
    checkOutput("exc_code", TRAP_CODE, 32'h0000_0002);
    checkOutput("exc_jmp", TRAP_JMP_TO, 32'h8000_0000);
    TRAP_ACK = 1'b1;
    applyStimulus(1);
    TRAP_ACK = 1'b0;
    checkOutput("exc_after_ack", 32'(TRAP_EN), 32'd0);

    // Two pending interrupts, served lowest index first
    resetDut();
    STAGE_PC[32*1 +: 32] = 32'h0000_0300;
    INT_MASK = 8'hFF; INT_ALLOW = 1'b1;
    TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h0000_1000;
    INT_REQ = 8'b0000_1010;
    applyStimulus(1);
    INT_REQ = '0;
    checkOutput("int_pending_set", 32'(INT_PENDING), 32'h0A);
    applyStimulus(1);
    checkOutput("int1_en", 32'(TRAP_EN), 32'd1);
    checkOutput("int1_code", TRAP_CODE, 32'h8000_0001);
    checkOutput("int1_jmp", TRAP_JMP_TO, 32'h0000_1004);
    checkOutput("int1_pc", TRAP_PC, 32'h0000_0300);
    TRAP_ACK = 1'b1;
    applyStimulus(1);
    TRAP_ACK = 1'b0;
    checkOutput("int1_taken", 32'(INT_PENDING), 32'h08);
    checkOutput("int1_dropped", 32'(TRAP_EN), 32'd0);
    FLUSH = 1'b1;
    applyStimulus(1);
    FLUSH = 1'b0;
    checkOutput("drain_no_trap", 32'(TRAP_EN), 32'd0);
    applyStimulus(1);
    checkOutput("idle_no_trap", 32'(TRAP_EN), 32'd0);
    applyStimulus(1);
    checkOutput("int3_en", 32'(TRAP_EN), 32'd1);
    checkOutput("int3_code", TRAP_CODE, 32'h8000_0003);
    checkOutput("int3_jmp", TRAP_JMP_TO, 32'h0000_100C);

    // Exception and interrupt together: exception wins, pending bit survives
    resetDut();
    STAGE_PC[31:0] = 32'h0000_0500;
    INT_MASK = 8'hFF; INT_ALLOW = 1'b1;
    TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h0000_2000;
    EXC_EN = 1'b1; EXC_CODE = 4'd5; INT_REQ = 8'h04;
    applyStimulus(1);
    EXC_EN = 1'b0; INT_REQ = '0;
    applyStimulus(1);
    checkOutput("mix_en", 32'(TRAP_EN), 32'd1);
    checkOutput("mix_code", TRAP_CODE, 32'h0000_0005);
    checkOutput("mix_jmp", TRAP_JMP_TO, 32'h0000_2000);
    checkOutput("mix_pc", TRAP_PC, 32'h0000_0500);
    TRAP_ACK = 1'b1;
    applyStimulus(1);
    TRAP_ACK = 1'b0;
    checkOutput("mix_pending_kept", 32'(INT_PENDING), 32'h04);
    INT_REQ = 8'h04; INT_CLR = 8'h04;
    applyStimulus(1);
    checkOutput("set_beats_clear", 32'(INT_PENDING), 32'h04);
    INT_REQ = '0;
    applyStimulus(1);
    INT_CLR = '0;
    checkOutput("sw_clear", 32'(INT_PENDING), 32'h00);

    // MMU stall for three cycles from the exception cycle
    resetDut();
    STAGE_PC[31:0] = 32'h0000_0040;
    EXC_EN = 1'b1; EXC_CODE = 4'd7; MMU_WAIT = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("mmu_stall_c%0d", c), 32'(TRAP_EN), 32'd0);
    end
    MMU_WAIT = 1'b0;
    applyStimulus(1);
    EXC_EN = 1'b0;
    checkOutput("mmu_c4", 32'(TRAP_EN), 32'd0);
    applyStimulus(1);
    checkOutput("mmu_c5_en", 32'(TRAP_EN), 32'd1);
    checkOutput("mmu_code", TRAP_CODE, 32'h0000_0007);
    MMU_WAIT = 1'b1; TRAP_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("ack_ignored_stall", 32'(TRAP_EN), 32'd1);
    MMU_WAIT = 1'b0;
    applyStimulus(1);
    TRAP_ACK = 1'b0;
    checkOutput("ack_after_stall", 32'(TRAP_EN), 32'd0);

    // Mode change with PC+4 wrap, then a trap suppressing it
    resetDut();
    STAGE_PC[31:0] = 32'hFFFF_FFFC;
    CHMODE_DO_IN = 1'b1; CHMODE_TRANS_TO_IN = 2'd3;
    applyStimulus(2);
    checkOutput("chm_do", 32'(CHMODE_DO), 32'd1);
    checkOutput("chm_to", 32'(CHMODE_TRANS_TO), 32'd3);
    checkOutput("chm_jmp_wrap", CHMODE_JMP_TO, 32'h0000_0000);
    checkOutput("chm_no_trap", 32'(TRAP_EN), 32'd0);
    EXC_EN = 1'b1; EXC_CODE = 4'd1;
    applyStimulus(1);
    EXC_EN = 1'b0;
    checkOutput("chm_before_trap", 32'(CHMODE_DO), 32'd1);
    applyStimulus(1);
    checkOutput("chm_trap_wins", 32'(CHMODE_DO), 32'd0);
    checkOutput("chm_trap_en", 32'(TRAP_EN), 32'd1);

    // Asynchronous reset while a trap is being issued
    resetDut();
    STAGE_PC[31:0] = 32'h0000_0700;
    TRAP_VEC_BASE = 32'h0000_3000;
    EXC_EN = 1'b1; EXC_CODE = 4'd3; INT_MASK = 8'hFF; INT_REQ = 8'h10;
    applyStimulus(1);
    EXC_EN = 1'b0; INT_REQ = '0;
    applyStimulus(1);
    checkOutput("rst_pre_en", 32'(TRAP_EN), 32'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("rst_async_en", 32'(TRAP_EN), 32'd0);
    checkOutput("rst_async_pc", TRAP_PC, 32'd0);
    checkOutput("rst_async_code", TRAP_CODE, 32'd0);
    checkOutput("rst_async_jmp", TRAP_JMP_TO, 32'd0);
    checkOutput("rst_async_pend", 32'(INT_PENDING), 32'd0);
    clearInputs();
    applyStimulus(1);
    RST_N = 1'b1;
    applyStimulus(2);
    checkOutput("rst_idle_quiet", 32'(TRAP_EN), 32'd0);
    STAGE_PC[31:0] = 32'h0000_0800;
    EXC_EN = 1'b1; EXC_CODE = 4'd9;
    applyStimulus(1);
    EXC_EN = 1'b0;
    applyStimulus(1);
    checkOutput("rst_idle_retrap", 32'(TRAP_EN), 32'd1);
    checkOutput("rst_idle_code", TRAP_CODE, 32'h0000_0009);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
